// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// bubble word, PC step and small PC arithmetic helpers.
package fetch_stage_pkg;

    // REQ: a fetch of the current PC is outstanding.
    // BUF: one fetched word is parked in the skid buffer waiting for decode.
    typedef enum logic [0:0] {
        ST_REQ = 1'b0,
        ST_BUF = 1'b1
    } fetch_state_e;

    // Instruction word presented in IF/ID when it holds a bubble.
    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

    // Sequential PC step (one 32-bit instruction).
    localparam logic [31:0] PC_INC        = 32'h0000_0004;

    // Clears the byte-offset bits of a redirect target.
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    // Next sequential PC; the addition wraps modulo 2^32 by construction.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

    // Word-aligned version of a redirect address.
    function automatic logic [31:0] pc_align(input logic [31:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds the PC, instruction word and valid flag of
// the instruction handed to decode. Loads on we, clears on rst or clr.
import fetch_stage_pkg::*;

module if_id_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        we,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    input  logic        valid_in,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        valid_out
);

    // Register update: clear has priority over load, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pc_out    <= 32'h0000_0000;
            inst_out  <= NOP_WORD;
            valid_out <= 1'b0;
        end else if (we) begin
            pc_out    <= pc_in;
            inst_out  <= inst_in;
            valid_out <= valid_in;
        end else begin
            pc_out    <= pc_out;
            inst_out  <= inst_out;
            valid_out <= valid_out;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, a two-state fetch FSM and a one-entry
// skid buffer that catches a returning word while decode is stalled.
import fetch_stage_pkg::*;

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IF_ID_Write,
    input  logic        flush,
    input  logic [31:0] target_PC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_number_out,
    output logic [31:0] inst_out,
    output logic        valid_out
);

    fetch_state_e state_r;
    logic [31:0]  pc_r;
    logic [31:0]  buf_pc_r;
    logic [31:0]  buf_inst_r;

    logic         ifid_we_s;
    logic         ifid_clr_s;
    logic [31:0]  ifid_pc_s;
    logic [31:0]  ifid_inst_s;
    logic         ifid_valid_s;

    // The memory request is a pure function of state so it never depends on
    // the response it is waiting for.
    assign imem_req  = (state_r == ST_REQ) && !rst;
    assign imem_addr = pc_r;

    // IF/ID write control: a flush squashes whatever arrives this cycle;
    // otherwise decode receives either the live memory word, a bubble, or
    // the parked skid-buffer entry.
    always_comb begin
        ifid_we_s    = 1'b0;
        ifid_clr_s   = 1'b0;
        ifid_pc_s    = pc_r;
        ifid_inst_s  = NOP_WORD;
        ifid_valid_s = 1'b0;
        if (flush) begin
            ifid_clr_s = 1'b1;
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (IF_ID_Write) begin
                        ifid_we_s = 1'b1;
                        if (imem_ready) begin
                            ifid_inst_s  = imem_rdata;
                            ifid_valid_s = 1'b1;
                        end else begin
                            ifid_inst_s  = NOP_WORD;
                            ifid_valid_s = 1'b0;
                        end
                    end else begin
                        ifid_we_s = 1'b0;
                    end
                end
                ST_BUF: begin
                    if (IF_ID_Write) begin
                        ifid_we_s    = 1'b1;
                        ifid_pc_s    = buf_pc_r;
                        ifid_inst_s  = buf_inst_r;
                        ifid_valid_s = 1'b1;
                    end else begin
                        ifid_we_s = 1'b0;
                    end
                end
                default: begin
                    ifid_we_s = 1'b0;
                end
            endcase
        end
    end

    // Fetch FSM, PC and skid buffer. Reset beats flush, flush beats
    // everything else; a word returned while decode is stalled is parked
    // and the PC advances so the next fetch is already lined up.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_REQ;
            pc_r       <= RESET_PC;
            buf_pc_r   <= 32'h0000_0000;
            buf_inst_r <= NOP_WORD;
        end else if (flush) begin
            state_r    <= ST_REQ;
            pc_r       <= pc_align(target_PC);
            buf_pc_r   <= 32'h0000_0000;
            buf_inst_r <= NOP_WORD;
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (imem_ready) begin
                        pc_r <= pc_next(pc_r);
                        if (IF_ID_Write) begin
                            state_r <= ST_REQ;
                        end else begin
                            state_r    <= ST_BUF;
                            buf_pc_r   <= pc_r;
                            buf_inst_r <= imem_rdata;
                        end
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_BUF: begin
                    if (IF_ID_Write) begin
                        state_r <= ST_REQ;
                    end else begin
                        state_r <= ST_BUF;
                    end
                end
                default: begin
                    state_r <= ST_REQ;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .clr       (ifid_clr_s),
        .we        (ifid_we_s),
        .pc_in     (ifid_pc_s),
        .inst_in   (ifid_inst_s),
        .valid_in  (ifid_valid_s),
        .pc_out    (PC_number_out),
        .inst_out  (inst_out),
        .valid_out (valid_out)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table walks the default-reset
// instance through streaming, stalls, bubbles, flushes and reset; a second
// instance checks PC wrap-around from a high reset address.
module tb_fetch_stage;

    logic        clk;
    int          n_checks;
    int          n_fail;

    // Instance 0 (RESET_PC = 0)
    logic        rst0, wr0, flush0, rdy0;
    logic [31:0] tgt0, rdata0, addr0, pco0, insto0;
    logic        req0, valido0;

    // Instance 1 (RESET_PC = FFFF_FFF8)
    logic        rst1, wr1, flush1, rdy1;
    logic [31:0] tgt1, rdata1, addr1, pco1, insto1;
    logic        req1, valido1;

    // Instruction memory contents: a recognisable word derived from address.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return 32'h1300_0000 ^ a;
    endfunction

    assign rdata0 = inst_of(addr0);
    assign rdata1 = inst_of(addr1);

    fetch_stage dut0 (
        .clk(clk), .rst(rst0), .IF_ID_Write(wr0), .flush(flush0), .target_PC(tgt0),
        .imem_req(req0), .imem_addr(addr0), .imem_ready(rdy0), .imem_rdata(rdata0),
        .PC_number_out(pco0), .inst_out(insto0), .valid_out(valido0)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .rst(rst1), .IF_ID_Write(wr1), .flush(flush1), .target_PC(tgt1),
        .imem_req(req1), .imem_addr(addr1), .imem_ready(rdy1), .imem_rdata(rdata1),
        .PC_number_out(pco1), .inst_out(insto1), .valid_out(valido1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        flush;
        logic [31:0] tgt;
        logic        wr;
        logic        rdy;
        logic        e_req;    // before the edge
        logic [31:0] e_addr;   // before the edge
        logic [31:0] e_pc;     // IF/ID after the edge
        logic        e_valid;  // IF/ID after the edge
    } vec_t;

    vec_t vt[22];

    function automatic vec_t mk(input logic r, input logic f, input logic [31:0] t,
                                input logic w, input logic y, input logic eq,
                                input logic [31:0] ea, input logic [31:0] ep,
                                input logic ev);
        vec_t v;
        v.rst = r; v.flush = f; v.tgt = t; v.wr = w; v.rdy = y;
        v.e_req = eq; v.e_addr = ea; v.e_pc = ep; v.e_valid = ev;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //          rst   flush tgt            wr    rdy   req   addr           if/id pc       valid
        vt[0]  = mk(1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);
        vt[1]  = mk(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1);
        vt[2]  = mk(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_0004, 1'b1);
        vt[3]  = mk(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'h0000_0004, 1'b1);
        vt[4]  = mk(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'h0000_0004, 1'b1);
        vt[5]  = mk(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_000C, 32'h0000_0004, 1'b1);
        vt[6]  = mk(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_000C, 32'h0000_0008, 1'b1);
        vt[7]  = mk(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_000C, 32'h0000_000C, 1'b1);
        vt[8]  = mk(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0010, 1'b0);
        vt[9]  = mk(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0010, 1'b0);
        vt[10] = mk(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0010, 1'b1);
        vt[11] = mk(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b1, 1'b1, 32'h0000_0014, 32'h0000_0000, 1'b0);
        vt[12] = mk(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0100, 1'b1);
        vt[13] = mk(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0104, 32'h0000_0100, 1'b1);
        vt[14] = mk(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b1, 1'b0, 32'h0000_0108, 32'h0000_0000, 1'b0);
        vt[15] = mk(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0200, 1'b1);
        vt[16] = mk(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0204, 32'h0000_0200, 1'b1);
        vt[17] = mk(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0204, 32'h0000_0200, 1'b1);
        vt[18] = mk(1'b1, 1'b1, 32'h0000_0300, 1'b1, 1'b1, 1'b0, 32'h0000_0208, 32'h0000_0000, 1'b0);
        vt[19] = mk(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1);
        vt[20] = mk(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_0000, 1'b0);
        vt[21] = mk(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0040, 1'b1);

        // Initial reset of both instances; instance 1 stays in reset for now.
        rst0 = 1'b1; wr0 = 1'b1; flush0 = 1'b0; rdy0 = 1'b1; tgt0 = 32'h0000_0000;
        rst1 = 1'b1; wr1 = 1'b1; flush1 = 1'b0; rdy1 = 1'b1; tgt1 = 32'h0000_0000;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 22; i++) begin
            rst0   = vt[i].rst;
            flush0 = vt[i].flush;
            tgt0   = vt[i].tgt;
            wr0    = vt[i].wr;
            rdy0   = vt[i].rdy;
            #1;
            check($sformatf("v%0d imem_req", i), {31'd0, req0}, {31'd0, vt[i].e_req});
            check($sformatf("v%0d imem_addr", i), addr0, vt[i].e_addr);
            @(posedge clk);
            #1;
            check($sformatf("v%0d pc_out", i), pco0, vt[i].e_pc);
            check($sformatf("v%0d inst_out", i), insto0,
                  vt[i].e_valid ? inst_of(vt[i].e_pc) : 32'h0000_0000);
            check($sformatf("v%0d valid_out", i), {31'd0, valido0}, {31'd0, vt[i].e_valid});
            @(negedge clk);
        end

        // PC wrap from RESET_PC = FFFF_FFF8 with streaming fetch.
        check("wrap reset addr", addr1, 32'hFFFF_FFF8);
        check("wrap reset req", {31'd0, req1}, 32'h0000_0000);
        rst1 = 1'b0;
        begin
            logic [31:0] exp_a [3];
            exp_a[0] = 32'hFFFF_FFF8;
            exp_a[1] = 32'hFFFF_FFFC;
            exp_a[2] = 32'h0000_0000;
            for (int k = 0; k < 3; k++) begin
                #1;
                check($sformatf("wrap%0d imem_addr", k), addr1, exp_a[k]);
                check($sformatf("wrap%0d imem_req", k), {31'd0, req1}, 32'h0000_0001);
                @(posedge clk);
                #1;
                check($sformatf("wrap%0d pc_out", k), pco1, exp_a[k]);
                check($sformatf("wrap%0d inst_out", k), insto1, inst_of(exp_a[k]));
                check($sformatf("wrap%0d valid_out", k), {31'd0, valido1}, 32'h0000_0001);
                @(negedge clk);
            end
        end
        check("wrap next addr", addr1, 32'h0000_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
